// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect, instruction-memory port and
// the instruction stream handed to the core.
interface instr_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    input  redirect,
    input  redirect_pc,
    input  mem_ack,
    input  mem_rdata,
    input  instr_ready,
    output mem_req,
    output mem_addr,
    output instr_valid,
    output instr,
    output instr_pc
  );

  modport slave (
    output redirect,
    output redirect_pc,
    output mem_ack,
    output mem_rdata,
    output instr_ready,
    input  mem_req,
    input  mem_addr,
    input  instr_valid,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: walks the PC through instruction memory with one
// outstanding request and buffers fetched words in a small FIFO.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic               clock,
  input logic               reset,
  instr_fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  state_t      state;
  state_t      state_nx;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nx;
  logic [31:0] mem_addr_q;
  logic        issue;
  logic        do_enq;
  logic        do_deq;

  assign bus.mem_req     = (state != S_IDLE);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = fifo_q[rd_ptr].instr;
  assign bus.instr_pc    = fifo_q[rd_ptr].pc;

  // A redirect squashes this cycle's pop as well as any push.
  assign do_deq = bus.instr_valid && bus.instr_ready
                  && !bus.redirect;

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    issue       = 1'b0;
    do_enq      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!bus.redirect &&
            count < (AW+1)'(DEPTH)) begin
          issue    = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          state_nx = S_IDLE;
          if (!bus.redirect) begin
            do_enq      = 1'b1;
            fetch_pc_nx = mem_addr_q + 32'd4;
          end
        end else if (bus.redirect) begin
          state_nx = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.mem_ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (bus.redirect)
      fetch_pc_nx = bus.redirect_pc & ~32'h3;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      mem_addr_q <= RESET_PC;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      if (issue) mem_addr_q <= fetch_pc;
      if (bus.redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_enq) wr_ptr <= wr_ptr + AW'(1);
        if (do_deq) rd_ptr <= rd_ptr + AW'(1);
        unique case ({do_enq, do_deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_enq && !reset)
      fifo_q[wr_ptr] <= '{instr: bus.mem_rdata,
                          pc:    mem_addr_q};
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: ordering, backpressure,
// redirects, reset mid-request and PC wrap.
module tb_instr_fetch_queue;

  logic clk;
  logic reset;
  logic ready;
  logic redirect;
  logic [31:0] redirect_pc;
  logic en_mem;
  logic man_ack;
  logic [31:0] man_rdata;
  logic auto_ack;
  logic [31:0] auto_rdata;
  int   lat;
  int   wcnt;
  int   checks;
  int   errors;
  int   nack;
  int   nack_base;
  int   gbase;
  int   cyc;
  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];
  logic [31:0] a2[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  instr_fetch_queue_if b1 ();
  instr_fetch_queue_if b2 ();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u1 (
    .clock(clk), .reset(reset), .bus(b1));

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u2 (
    .clock(clk), .reset(reset), .bus(b2));

  assign b1.redirect    = redirect;
  assign b1.redirect_pc = redirect_pc;
  assign b1.instr_ready = ready;
  assign b1.mem_ack     = en_mem ? auto_ack : man_ack;
  assign b1.mem_rdata   = en_mem ? auto_rdata : man_rdata;

  assign b2.redirect    = 1'b0;
  assign b2.redirect_pc = 32'h0;
  assign b2.instr_ready = 1'b1;
  assign b2.mem_ack     = b2.mem_req;
  assign b2.mem_rdata   = mem_word(b2.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    auto_ack = 1'b0;
    if (!en_mem || !b1.mem_req) begin
      wcnt = 0;
    end else if (wcnt >= lat) begin
      auto_ack   = 1'b1;
      auto_rdata = mem_word(b1.mem_addr);
      wcnt       = 0;
    end else begin
      wcnt = wcnt + 1;
    end
  end

  always @(posedge clk) begin
    if (b1.mem_req && b1.mem_ack) nack = nack + 1;
    if (!reset && !redirect && b1.instr_valid && ready) begin
      got_pc.push_back(b1.instr_pc);
      got_in.push_back(b1.instr);
    end
    if (!reset && b2.mem_req && b2.mem_ack && a2.size() < 4)
      a2.push_back(b2.mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; errors = 0; nack = 0; wcnt = 0;
    auto_ack = 1'b0; auto_rdata = '0;
    reset = 1'b1; ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; en_mem = 1'b1; lat = 0;
    man_ack = 1'b0; man_rdata = '0;
    repeat (3) tick();

    chk("rst_req", 32'(b1.mem_req), 0);
    chk("rst_addr", b1.mem_addr, 32'h0);
    chk("rst_valid", 32'(b1.instr_valid), 0);
    chk("rst_addr2", b2.mem_addr, 32'hFFFF_FFF8);

    // in-order delivery, zero-latency ack
    ready = 1'b1;
    reset = 1'b0;
    cyc = 0;
    while (!b1.instr_valid && cyc < 10) begin
      tick();
      cyc = cyc + 1;
    end
    chk("first_valid_lat", 32'(cyc <= 3), 1);
    gbase = got_pc.size();
    cyc = 0;
    while (got_pc.size() < gbase + 4 && cyc < 40) begin
      tick();
      cyc = cyc + 1;
    end
    ready = 1'b0;
    chk("t1_count", 32'(got_pc.size() >= gbase + 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (got_pc.size() > gbase + i) begin
        chk("t1_pc", got_pc[gbase+i], 32'(i * 4));
        chk("t1_instr", got_in[gbase+i], mem_word(32'(i * 4)));
      end
    end

    // backpressure fills exactly four entries
    reset = 1'b1;
    repeat (2) tick();
    nack_base = nack;
    reset = 1'b0;
    repeat (30) tick();
    chk("t2_acks", 32'(nack - nack_base), 4);
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_idle", 32'(b1.mem_req), 0);
      tick();
    end
    chk("t2_valid", 32'(b1.instr_valid), 1);
    chk("t2_head_pc", b1.instr_pc, 32'h0);
    ready = 1'b1;
    gbase = got_pc.size();
    cyc = 0;
    while (got_pc.size() < gbase + 5 && cyc < 40) begin
      tick();
      cyc = cyc + 1;
    end
    ready = 1'b0;
    chk("t2_count", 32'(got_pc.size() >= gbase + 5), 1);
    for (int i = 0; i < 5; i++) begin
      if (got_pc.size() > gbase + i)
        chk("t2_pc", got_pc[gbase+i], 32'(i * 4));
    end

    // redirect while idle with three buffered words
    reset = 1'b1;
    repeat (2) tick();
    nack_base = nack;
    reset = 1'b0;
    cyc = 0;
    while (nack - nack_base < 3 && cyc < 20) begin
      tick();
      cyc = cyc + 1;
    end
    chk("t3_acks", 32'(nack - nack_base), 3);
    chk("t3_req_idle", 32'(b1.mem_req), 0);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("t3_flush_valid", 32'(b1.instr_valid), 0);
    chk("t3_flush_req", 32'(b1.mem_req), 0);
    ready = 1'b1;
    gbase = got_pc.size();
    cyc = 0;
    while (got_pc.size() <= gbase && cyc < 20) begin
      tick();
      cyc = cyc + 1;
    end
    ready = 1'b0;
    chk("t3_got", 32'(got_pc.size() > gbase), 1);
    if (got_pc.size() > gbase) begin
      chk("t3_pc", got_pc[gbase], 32'h40);
      chk("t3_instr", got_in[gbase], mem_word(32'h40));
    end

    // redirect during outstanding requests, slow memory
    reset = 1'b1;
    en_mem = 1'b0;
    ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("t4_req0", 32'(b1.mem_req), 1);
    chk("t4_addr0", b1.mem_addr, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    chk("t4_hold_addr0", b1.mem_addr, 32'h0);
    man_ack = 1'b1;
    man_rdata = 32'hBAD0_0000;
    tick();
    man_ack = 1'b0;
    chk("t4_drop0", 32'(b1.instr_valid), 0);
    tick();
    chk("t4_req20", 32'(b1.mem_req), 1);
    chk("t4_addr20", b1.mem_addr, 32'h20);
    redirect = 1'b1;
    redirect_pc = 32'h101;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_hold_req", 32'(b1.mem_req), 1);
      chk("t4_hold_addr", b1.mem_addr, 32'h20);
      tick();
    end
    man_ack = 1'b1;
    man_rdata = mem_word(32'h20);
    tick();
    man_ack = 1'b0;
    chk("t4_drop20", 32'(b1.instr_valid), 0);
    chk("t4_req_gap", 32'(b1.mem_req), 0);
    tick();
    chk("t4_req100", 32'(b1.mem_req), 1);
    chk("t4_addr100", b1.mem_addr, 32'h100);
    man_ack = 1'b1;
    man_rdata = mem_word(32'h100);
    tick();
    man_ack = 1'b0;
    chk("t4_valid100", 32'(b1.instr_valid), 1);
    chk("t4_pc100", b1.instr_pc, 32'h100);
    chk("t4_instr100", b1.instr, mem_word(32'h100));

    // reset while a request is outstanding
    tick();
    chk("t5_req104", 32'(b1.mem_req), 1);
    chk("t5_addr104", b1.mem_addr, 32'h104);
    reset = 1'b1;
    tick();
    chk("t5_rst_req", 32'(b1.mem_req), 0);
    chk("t5_rst_addr", b1.mem_addr, 32'h0);
    chk("t5_rst_valid", 32'(b1.instr_valid), 0);
    reset = 1'b0;
    man_ack = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    man_ack = 1'b0;
    chk("t5_late_ack", 32'(b1.instr_valid), 0);
    chk("t5_restart_req", 32'(b1.mem_req), 1);
    chk("t5_restart_addr", b1.mem_addr, 32'h0);
    man_ack = 1'b1;
    man_rdata = mem_word(32'h0);
    tick();
    man_ack = 1'b0;
    chk("t5_valid", 32'(b1.instr_valid), 1);
    chk("t5_pc", b1.instr_pc, 32'h0);
    chk("t5_instr", b1.instr, mem_word(32'h0));

    // address wrap on the second instance
    chk("t6_count", 32'(a2.size()), 4);
    if (a2.size() == 4) begin
      chk("t6_a0", a2[0], 32'hFFFF_FFF8);
      chk("t6_a1", a2[1], 32'hFFFF_FFFC);
      chk("t6_a2", a2[2], 32'h0000_0000);
      chk("t6_a3", a2[3], 32'h0000_0004);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
